// File: rtl/atmospheric_light_est.sv
// rtl/atmospheric_light_est.sv - per-frame atmospheric light estimator with clamp and IIR smoothing
// Tracks the brightest channel of the pixel with the highest dark value per frame and publishes it after vsync falls.
module atmospheric_light_est #(
    parameter logic [7:0] A_INIT    = 8'd230,
    parameter logic [7:0] A_MIN     = 8'd100,
    parameter logic [7:0] A_MAX     = 8'd245,
    parameter int         IIR_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pre_frame_vsync,
    input  logic        pre_frame_href,
    input  logic        pre_frame_clken,
    input  logic [7:0]  pre_dark_img,
    input  logic [23:0] pre_img,
    output logic [7:0]  post_A,
    output logic        post_A_valid
);
    localparam int W = 8 + IIR_SHIFT + 1;
    localparam logic [W-1:0] MUL = W'((1 << IIR_SHIFT) - 1);
    localparam logic [W-1:0] RND = W'((1 << IIR_SHIFT) >> 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_UPDATE} state_t;

    state_t     r_state;
    logic       r_vsync_d1;
    logic       r_first;
    logic [7:0] r_max_dark;
    logic [7:0] r_cand;
    logic [7:0] r_post_a;
    logic       r_post_a_valid;

    logic         w_rise;
    logic         w_fall;
    logic         w_take;
    logic [7:0]   w_m;
    logic [7:0]   w_base_max;
    logic [7:0]   w_base_cand;
    logic [7:0]   w_next_max;
    logic [7:0]   w_next_cand;
    logic [7:0]   w_a_frm;
    logic [W-1:0] w_iir_sum;
    logic [W-1:0] w_iir_shr;
    logic [7:0]   w_a_new;

    assign w_rise = pre_frame_vsync & ~r_vsync_d1;
    assign w_fall = ~pre_frame_vsync & r_vsync_d1;
    assign w_take = pre_frame_href & pre_frame_clken & pre_frame_vsync
                  & ((r_state == S_ACCUM) | w_rise);

    // A rising edge restarts the frame, so its own pixel is compared against cleared accumulators.
    assign w_base_max  = w_rise ? 8'd0 : r_max_dark;
    assign w_base_cand = w_rise ? 8'd0 : r_cand;

    always_comb begin
        w_m = pre_img[23:16];
        if (pre_img[15:8] > w_m) w_m = pre_img[15:8];
        if (pre_img[7:0] > w_m)  w_m = pre_img[7:0];
        w_next_max  = w_base_max;
        w_next_cand = w_base_cand;
        if (w_take) begin
            if (pre_dark_img > w_base_max) begin
                w_next_max  = pre_dark_img;
                w_next_cand = w_m;
            end else if (pre_dark_img == w_base_max && w_m > w_base_cand) begin
                w_next_cand = w_m;
            end
        end
    end

    assign w_a_frm   = (r_cand < A_MIN) ? A_MIN : ((r_cand > A_MAX) ? A_MAX : r_cand);
    assign w_iir_sum = {{(W-8){1'b0}}, r_post_a} * MUL + {{(W-8){1'b0}}, w_a_frm} + RND;
    assign w_iir_shr = w_iir_sum >> IIR_SHIFT;
    assign w_a_new   = w_iir_shr[7:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_vsync_d1     <= 1'b1;
            r_first        <= 1'b1;
            r_max_dark     <= 8'd0;
            r_cand         <= 8'd0;
            r_post_a       <= A_INIT;
            r_post_a_valid <= 1'b0;
        end else begin
            r_vsync_d1     <= pre_frame_vsync;
            r_post_a_valid <= 1'b0;
            if (w_take || w_rise) begin
                r_max_dark <= w_next_max;
                r_cand     <= w_next_cand;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_rise) r_state <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (w_fall) r_state <= S_UPDATE;
                end
                S_UPDATE: begin
                    r_post_a       <= r_first ? w_a_frm : w_a_new;
                    r_first        <= 1'b0;
                    r_post_a_valid <= 1'b1;
                    r_state        <= w_rise ? S_ACCUM : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign post_A       = r_post_a;
    assign post_A_valid = r_post_a_valid;
endmodule

// File: tb/tb_atmospheric_light_est.sv
// tb/tb_atmospheric_light_est.sv - self-checking bench for atmospheric_light_est
module tb_atmospheric_light_est;
    localparam int K = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vsync;
    logic        href;
    logic        clken;
    logic [7:0]  dark;
    logic [23:0] img;
    logic [7:0]  post_a;
    logic        valid;

    int errors = 0;
    int checks = 0;
    int model_a;
    bit model_first;
    logic [31:0] frame_q[$];

    atmospheric_light_est dut (
        .clk(clk), .rst_n(rst_n), .pre_frame_vsync(vsync), .pre_frame_href(href),
        .pre_frame_clken(clken), .pre_dark_img(dark), .pre_img(img),
        .post_A(post_a), .post_A_valid(valid)
    );

    always #5 clk = ~clk;

    function automatic int max3(input logic [23:0] p);
        int m;
        m = int'(p[23:16]);
        if (int'(p[15:8]) > m) m = int'(p[15:8]);
        if (int'(p[7:0]) > m)  m = int'(p[7:0]);
        return m;
    endfunction

    // Brightest channel among the pixels sharing the frame's highest dark value.
    function automatic int frame_cand();
        int maxd = -1;
        int c = 0;
        foreach (frame_q[i]) if (int'(frame_q[i][31:24]) > maxd) maxd = int'(frame_q[i][31:24]);
        foreach (frame_q[i])
            if (int'(frame_q[i][31:24]) == maxd && max3(frame_q[i][23:0]) > c) c = max3(frame_q[i][23:0]);
        return c;
    endfunction

    function automatic int expect_a(input int cand);
        int frm;
        frm = (cand < 100) ? 100 : ((cand > 245) ? 245 : cand);
        if (model_first) return frm;
        return (model_a * ((1 << K) - 1) + frm + (1 << (K - 1))) >> K;
    endfunction

    function automatic logic [31:0] pix(input int d, input int r, input int g, input int b);
        return {8'(d), 8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) begin href = 1'b1; clken = 1'b0; end
            else begin href = 1'b0; clken = 1'b1; end
            dark = 8'($urandom);
            img  = 24'($urandom);
            tick();
        end
        href  = 1'b0;
        clken = 1'b0;
    endtask

    task automatic put_pix(input logic [31:0] p);
        href  = 1'b1;
        clken = 1'b1;
        dark  = p[31:24];
        img   = p[23:0];
    endtask

    task automatic drive_rest(input int start);
        for (int i = start; i < frame_q.size(); i++) begin
            idle_gap($urandom_range(0, 2));
            put_pix(frame_q[i]);
            tick();
            href  = 1'b0;
            clken = 1'b0;
        end
        idle_gap($urandom_range(0, 2));
        vsync = 1'b0;
    endtask

    task automatic drive_frame(input bit pix_in_rise);
        vsync = 1'b1;
        if (pix_in_rise) put_pix(frame_q[0]);
        tick();
        href  = 1'b0;
        clken = 1'b0;
        drive_rest(pix_in_rise ? 1 : 0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        vsync = 1'b0;
        href  = 1'b0;
        clken = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
        model_a = 230;
        model_first = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(3);
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (post_a !== 8'd230 || valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: post_A=%0d valid=%0b, want post_A=230 valid=0", i, post_a, valid);
            end
        end
    endtask

    task automatic test_clamp();
        int exp;
        do_reset(2);
        idle_gap(3);
        frame_q = {};
        for (int i = 0; i < 16; i++)
            frame_q.push_back(i == 6 ? pix(200, 250, 240, 230) : {8'($urandom_range(0, 100)), 24'($urandom)});
        exp = expect_a(frame_cand());
        drive_frame(1'b0);
        tick();
        checks++;
        if (valid !== 1'b0 || post_a !== 8'd230) begin
            errors++;
            $display("FAIL clamp_t1: post_A=%0d valid=%0b, want post_A=230 valid=0", post_a, valid);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || post_a !== 8'(exp)) begin
            errors++;
            $display("FAIL clamp_t2: post_A=%0d valid=%0b, want post_A=%0d valid=1", post_a, valid, exp);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || post_a !== 8'(exp)) begin
            errors++;
            $display("FAIL clamp_t3: post_A=%0d valid=%0b, want post_A=%0d valid=0", post_a, valid, exp);
        end
        model_a = exp;
        model_first = 1'b0;
    endtask

    task automatic test_tie_blanking();
        int exp;
        do_reset(2);
        idle_gap(2);
        frame_q = {};
        for (int i = 0; i < 5; i++) frame_q.push_back({8'($urandom_range(0, 170)), 24'($urandom)});
        frame_q.push_back(pix(180, 210, 100, 50));
        for (int i = 0; i < 4; i++) frame_q.push_back({8'($urandom_range(0, 170)), 24'($urandom)});
        frame_q.push_back(pix(180, 90, 220, 10));
        for (int i = 0; i < 5; i++) frame_q.push_back({8'($urandom_range(0, 170)), 24'($urandom)});
        exp = expect_a(frame_cand());
        drive_frame(1'b1);
        tick();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL tie_t1: valid=%0b, want 0", valid);
        end
        // Single blanking cycle: next frame rises in the update cycle, carrying the winning pixel.
        frame_q = {};
        frame_q.push_back(pix(90, 120, 50, 60));
        for (int i = 0; i < 12; i++) frame_q.push_back({8'($urandom_range(0, 80)), 24'($urandom)});
        vsync = 1'b1;
        put_pix(frame_q[0]);
        tick();
        checks++;
        if (valid !== 1'b1 || post_a !== 8'(exp)) begin
            errors++;
            $display("FAIL tie_t2: post_A=%0d valid=%0b, want post_A=%0d valid=1", post_a, valid, exp);
        end
        model_a = exp;
        model_first = 1'b0;
        href  = 1'b0;
        clken = 1'b0;
        exp = expect_a(frame_cand());
        drive_rest(1);
        checks++;
        if (valid !== 1'b0 || post_a !== 8'(model_a)) begin
            errors++;
            $display("FAIL blank_hold: post_A=%0d valid=%0b, want post_A=%0d valid=0", post_a, valid, model_a);
        end
        tick();
        tick();
        checks++;
        if (valid !== 1'b1 || post_a !== 8'(exp)) begin
            errors++;
            $display("FAIL blank_iir: post_A=%0d valid=%0b, want post_A=%0d valid=1", post_a, valid, exp);
        end
        model_a = exp;
    endtask

    task automatic test_zero();
        int exp;
        do_reset(2);
        idle_gap(2);
        frame_q = {};
        for (int i = 0; i < 16; i++) frame_q.push_back(32'd0);
        exp = expect_a(frame_cand());
        drive_frame(1'($urandom_range(0, 1)));
        tick();
        tick();
        checks++;
        if (valid !== 1'b1 || post_a !== 8'(exp)) begin
            errors++;
            $display("FAIL zero_frame: post_A=%0d valid=%0b, want post_A=%0d valid=1", post_a, valid, exp);
        end
        model_a = exp;
        model_first = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int exp;
        idle_gap(3);
        vsync = 1'b1;
        tick();
        put_pix(pix(255, 255, 255, 255));
        tick();
        href = 1'b0;
        clken = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_a = 230;
        model_first = 1'b1;
        put_pix(pix(250, 10, 20, 30));
        tick();
        href = 1'b0;
        clken = 1'b0;
        tick();
        vsync = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (valid !== 1'b0 || post_a !== 8'd230) begin
                errors++;
                $display("FAIL midreset_nopulse cyc%0d: post_A=%0d valid=%0b, want post_A=230 valid=0", i, post_a, valid);
            end
        end
        frame_q = {};
        for (int i = 0; i < 10; i++) frame_q.push_back({8'($urandom_range(0, 200)), 24'($urandom)});
        exp = expect_a(frame_cand());
        drive_frame(1'b0);
        tick();
        tick();
        checks++;
        if (valid !== 1'b1 || post_a !== 8'(exp)) begin
            errors++;
            $display("FAIL midreset_first: post_A=%0d valid=%0b, want post_A=%0d valid=1", post_a, valid, exp);
        end
        model_a = exp;
        model_first = 1'b0;
    endtask

    task automatic test_random();
        int exp;
        do_reset(2);
        idle_gap(2);
        for (int f = 0; f < 12; f++) begin
            frame_q = {};
            for (int i = 0; i < int'($urandom_range(1, 20)); i++)
                frame_q.push_back({8'($urandom_range(0, 7) * 36), 24'($urandom)});
            exp = expect_a(frame_cand());
            drive_frame(1'($urandom_range(0, 1)));
            tick();
            checks++;
            if (valid !== 1'b0 || post_a !== 8'(model_a)) begin
                errors++;
                $display("FAIL rand%0d_t1: post_A=%0d valid=%0b, want post_A=%0d valid=0", f, post_a, valid, model_a);
            end
            tick();
            checks++;
            if (valid !== 1'b1 || post_a !== 8'(exp)) begin
                errors++;
                $display("FAIL rand%0d_t2: post_A=%0d valid=%0b, want post_A=%0d valid=1", f, post_a, valid, exp);
            end
            model_a = exp;
            model_first = 1'b0;
            idle_gap($urandom_range(1, 4));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        vsync = 1'b0;
        href  = 1'b0;
        clken = 1'b0;
        dark  = 8'd0;
        img   = 24'd0;
        test_reset();
        test_clamp();
        test_tie_blanking();
        test_zero();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
